data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Handshaked data-memory slave: the responder end of the processor's load/store interface.
- Accepts one read or write request at a time from the MIPS datapath (address from the ALU result, write data from the second register-file read port).
- Inserts a programmable number of wait states, then returns a one-cycle response carrying read data and an error flag.
- Replaces the zero-latency combinational data memory so the core can be exercised against realistic memory latency.

Parameters:
- ADDR_WIDTH, 8, word-index width; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, cycles inserted between request acceptance and the memory access edge; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present (driven from MemRead | MemWrite).
- req_write  in  1  1 = store, 0 = load (driven from MemWrite).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load data; meaningful only with resp_valid.
- resp_err  out  1  request was misaligned or out of range; meaningful only with resp_valid.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - State = IDLE, so req_ready = 1 and busy = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, wait counter = 0.
  - Memory array is not reset; contents are undefined until written.
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - req_ready = 1.
  - Acceptance = req_valid && req_ready sampled at rising edge E0.
  - At E0, capture req_addr, req_write and req_wdata, and compute err.
  - err = (addr[1:0] != 0) || (addr[31:ADDR_WIDTH+2] != 0).
  - If WAIT_CYCLES == 0, go to RESPOND and perform the access at E0.
  - Otherwise load counter = WAIT_CYCLES - 1 and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each edge.
  - At the edge where counter == 0, go to RESPOND and perform the access.
- Access edge (E0 + WAIT_CYCLES):
  - Write and !err: mem[addr[ADDR_WIDTH+1:2]] <= captured wdata; resp_rdata <= 0.
  - Read and !err: resp_rdata <= mem[word index].
  - err: no array write; resp_rdata <= 0; resp_err <= 1.
- RESPOND:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next edge returns to IDLE unconditionally.
  - resp_valid and resp_err drop to 0 at that edge; resp_rdata holds its value.
- Timing:
  - Latency: resp_valid is high during the cycle following edge E0 + WAIT_CYCLES.
  - Throughput: at most one transaction per WAIT_CYCLES + 2 cycles.
  - The earliest next acceptance is the edge ending the IDLE cycle immediately after RESPOND.
- Request inputs are ignored outside IDLE; a held req_valid is simply accepted at the next IDLE edge.
- Ordering: transactions are strictly serialized, so a read following a write to the same word returns the new data; there is no read/write collision case.
- Reset mid-transaction:
  - The transaction is abandoned and no response is produced.
  - A write whose access edge has not yet occurred is not committed.
  - req_ready is 1 immediately on rst assertion.

Decomposition:
- Package mips_mem_pkg holds:
  - State enum (IDLE, WAIT, RESPOND).
  - Word-alignment mask constant (2'b00).
  - WAIT_CYCLES legal maximum (15) and counter width (4).
- Sub-module data_mem_array:
  - Synchronous write and registered read.
  - Ports: clk, we, re, waddr/raddr index, wdata, rdata.
  - Instantiated once; the FSM and error check stay in data_mem_responder.

Test Plan:
- WAIT_CYCLES=2, after reset, write 0xDEADBEEF to 0x10:
  - Accepted at E0; resp_valid high during the cycle after E0+2 with resp_err=0; busy high from E0 to RESPOND.
  - Then read 0x10: resp_rdata=0xDEADBEEF, resp_err=0.
- Read at 0x13 (misaligned): resp_err=1 and resp_rdata=0 with resp_valid; a subsequent read of 0x10 still returns 0xDEADBEEF.
- ADDR_WIDTH=8, write 0xFFFFFFFF to 0x400 (out of range, max 0x3FC): resp_err=1; a read of 0x000 returns the prior value 0x12345678 unchanged.
- Back-to-back:
  - Hold req_valid=1 across two reads (0x0, 0x4); req_ready=0 during WAIT and RESPOND.
  - Second acceptance occurs exactly 2 edges after the first RESPOND begins.
  - Responses are spaced WAIT_CYCLES+2 = 4 cycles apart.
- Assert rst during WAIT of a write of 0xA5A5A5A5 to 0x20: no resp_valid occurs, req_ready=1 asynchronously, and a later read of 0x20 returns its pre-write value.
- WAIT_CYCLES=0 instance: a read accepted at E0 gives resp_valid during the cycle after E0; a continuous req_valid yields one response every 2 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package mips_mem_pkg;

    // Responder transaction states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Low address bits of a word-aligned byte address
    localparam logic [1:0] WORD_ALIGN = 2'b00;

    // Largest supported wait-state count and the counter width that holds it
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous write, registered read.
module data_mem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];
    logic [31:0] r_rdata;

    // Commit stores and capture load data on the access edge; read data holds otherwise
    // NOTE: no reset here so the array maps onto RAM; non-blocking keeps same-edge read/write ordering well defined.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, then strobes a response.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    // Counter preload; the acceptance edge already counts as the first wait cycle
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic                  r_rd_ok;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_write;
    logic [31:0]           r_wdata;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic                  w_req_err;
    logic                  w_zero_wait_acc;
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [31:0]           w_acc_wdata;
    logic [31:0]           w_arr_rdata;

    // Misaligned, or any byte-address bit above the array's reach is set
    assign w_req_idx       = req_addr[ADDR_WIDTH+1:2];
    assign w_req_err       = (req_addr[1:0] != WORD_ALIGN) ||
                             ((req_addr >> (ADDR_WIDTH + 2)) != '0);
    assign w_zero_wait_acc = (WAIT_CYCLES == 0) && (r_state == IDLE) && req_valid;

    // Array access: live request for zero-wait, captured request on the last wait edge
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_acc_idx   = r_idx;
        w_acc_wdata = r_wdata;
        if (w_zero_wait_acc) begin
            w_acc_idx   = w_req_idx;
            w_acc_wdata = req_wdata;
            w_we        = req_write && !w_req_err;
            w_re        = !req_write && !w_req_err;
        end else if ((r_state == WAIT) && (r_cnt == '0)) begin
            w_we = r_write && !r_err;
            w_re = !r_write && !r_err;
        end
    end

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .re    (w_re),
        .waddr (w_acc_idx),
        .raddr (w_acc_idx),
        .wdata (w_acc_wdata),
        .rdata (w_arr_rdata)
    );

    // Transaction FSM with registered response strobe and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_idx        <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_idx   <= w_req_idx;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_err   <= w_req_err;
                        if (WAIT_CYCLES == 0) begin
                            r_state      <= RESPOND;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_req_err;
                            r_rd_ok      <= !req_write && !w_req_err;
                        end else begin
                            r_cnt   <= WAIT_LOAD;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= RESPOND;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_rd_ok      <= !r_write && !r_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    // Read data deliberately holds; only the strobe and flag drop
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rd_ok ? w_arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (a_req_valid),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .req_ready  (a_req_ready),
        .resp_valid (a_resp_valid),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err),
        .busy       (a_busy)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_req_valid),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_ready  (b_req_ready),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err),
        .busy       (b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance A; lat = edges from acceptance until resp_valid is seen
    task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
        step();
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            step();
            lat++;
        end
        rdata = a_resp_rdata;
        err   = a_resp_err;
        step();
    endtask

    task automatic txn_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
        step();
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_resp_valid && lat < 20) begin
            step();
            lat++;
        end
        rdata = b_resp_rdata;
        err   = b_resp_err;
        step();
    endtask

    task automatic test_reset();
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0;
        rst = 1'b1;
        step(); step();
        n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", a_req_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        n_cmp++; if (a_resp_valid !== 1'b0 || a_resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp got=%b/%b exp=0/0", a_resp_valid, a_resp_err); end
        n_cmp++; if (a_resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=00000000", a_resp_rdata); end
        n_cmp++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b got=%b/%b exp=1/0", b_req_ready, b_resp_valid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h10; a_req_wdata = 32'hDEADBEEF;
        step();   // E0
        a_req_valid = 0;
        n_cmp++; if (a_busy !== 1'b1 || a_req_ready !== 1'b0 || a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_e0 busy/ready/valid got=%b%b%b exp=100", a_busy, a_req_ready, a_resp_valid); end
        step();   // E1
        n_cmp++; if (a_busy !== 1'b1 || a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_e1 busy/valid got=%b%b exp=10", a_busy, a_resp_valid); end
        step();   // E2: access edge
        n_cmp++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("FAIL wr_resp valid/err/busy got=%b%b%b exp=101", a_resp_valid, a_resp_err, a_busy); end
        step();   // E3: back to IDLE
        n_cmp++; if (a_resp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_done valid/busy/ready got=%b%b%b exp=001", a_resp_valid, a_busy, a_req_ready); end
        txn_a(1'b0, 32'h10, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL rd_10 got=%h err=%b exp=deadbeef err=0", rd, er); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        txn_a(1'b0, 32'h13, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 2) begin n_bad++; $display("FAIL misaligned got=%h err=%b lat=%0d exp=00000000 err=1 lat=2", rd, er, lat); end
        txn_a(1'b0, 32'h10, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL rd_after_misaligned got=%h err=%b exp=deadbeef err=0", rd, er); end
        n_cmp++; if (a_resp_rdata !== 32'hDEADBEEF || a_resp_err !== 1'b0) begin n_bad++; $display("FAIL rdata_hold got=%h err=%b exp=deadbeef err=0", a_resp_rdata, a_resp_err); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn_a(1'b1, 32'h0, 32'h12345678, rd, er, lat);
        txn_a(1'b1, 32'h400, 32'hFFFFFFFF, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL oor_write got=%h err=%b exp=00000000 err=1", rd, er); end
        txn_a(1'b1, 32'h3FC, 32'h0000BEEF, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_word_err got=%b exp=0", er); end
        txn_a(1'b0, 32'h0, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_bad++; $display("FAIL rd_0_after_oor got=%h err=%b exp=12345678 err=0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        logic exp_ready [7] = '{0, 0, 0, 1, 0, 0, 0};
        logic exp_valid [7] = '{0, 0, 1, 0, 0, 0, 1};
        txn_a(1'b1, 32'h0, 32'h11111111, rd, er, lat);
        txn_a(1'b1, 32'h4, 32'h22222222, rd, er, lat);
        a_req_valid = 1; a_req_write = 0; a_req_addr = 32'h0; a_req_wdata = '0;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++; if (a_req_ready !== exp_ready[i] || a_resp_valid !== exp_valid[i]) begin
                n_bad++; $display("FAIL b2b_step%0d ready/valid got=%b%b exp=%b%b", i, a_req_ready, a_resp_valid, exp_ready[i], exp_valid[i]);
            end
            if (i == 2) begin
                n_cmp++; if (a_resp_rdata !== 32'h11111111) begin n_bad++; $display("FAIL b2b_rd0 got=%h exp=11111111", a_resp_rdata); end
                a_req_addr = 32'h4;
            end
            if (i == 6) begin
                n_cmp++; if (a_resp_rdata !== 32'h22222222) begin n_bad++; $display("FAIL b2b_rd4 got=%h exp=22222222", a_resp_rdata); end
            end
        end
        a_req_valid = 0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        txn_a(1'b1, 32'h20, 32'h0BADF00D, rd, er, lat);
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h20; a_req_wdata = 32'hA5A5A5A5;
        step();   // accepted, now in WAIT
        a_req_valid = 0;
        step();   // last WAIT cycle, access would be the next edge
        rst = 1'b1;
        #1;
        n_cmp++; if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin n_bad++; $display("FAIL async_reset ready/busy got=%b%b exp=10", a_req_ready, a_busy); end
        step();
        n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_resp got=%b exp=0", a_resp_valid); end
        rst = 1'b0;
        step();
        n_cmp++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset valid/ready got=%b%b exp=01", a_resp_valid, a_req_ready); end
        txn_a(1'b0, 32'h20, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_bad++; $display("FAIL rd_20_after_reset got=%h err=%b exp=0badf00d err=0", rd, er); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat;
        logic exp_valid [4] = '{1, 0, 1, 0};
        logic exp_ready [4] = '{0, 1, 0, 1};
        txn_b(1'b1, 32'h8, 32'hCAFEF00D, rd, er, lat);
        n_cmp++; if (lat !== 0 || er !== 1'b0) begin n_bad++; $display("FAIL zw_write lat=%0d err=%b exp lat=0 err=0", lat, er); end
        txn_b(1'b0, 32'h8, '0, rd, er, lat);
        n_cmp++; if (rd !== 32'hCAFEF00D || lat !== 0) begin n_bad++; $display("FAIL zw_read got=%h lat=%0d exp=cafef00d lat=0", rd, lat); end
        txn_b(1'b0, 32'h2, '0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL zw_misaligned got=%h err=%b exp=00000000 err=1", rd, er); end
        b_req_valid = 1; b_req_write = 0; b_req_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (b_resp_valid !== exp_valid[i] || b_req_ready !== exp_ready[i]) begin
                n_bad++; $display("FAIL zw_stream%0d valid/ready got=%b%b exp=%b%b", i, b_resp_valid, b_req_ready, exp_valid[i], exp_ready[i]);
            end
        end
        b_req_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
